// File: rtl/prga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prga_pkg
// Purpose  : State encoding, printable-ASCII window and parameter legality
//            check shared by prga_drop and prga_step.
// Revision : 1.0 - initial release
// ============================================================================
package prga_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] IDLE   = 4'd0;
    localparam logic [STATE_W-1:0] LEN_RD = 4'd1;
    localparam logic [STATE_W-1:0] I_RD   = 4'd2;
    localparam logic [STATE_W-1:0] J_RD   = 4'd3;
    localparam logic [STATE_W-1:0] SWAP_J = 4'd4;
    localparam logic [STATE_W-1:0] SWAP_I = 4'd5;
    localparam logic [STATE_W-1:0] K_RD   = 4'd6;
    localparam logic [STATE_W-1:0] PT_WR  = 4'd7;
    localparam logic [STATE_W-1:0] DONE   = 4'd8;

    localparam logic [7:0] ASCII_LO = 8'h20;
    localparam logic [7:0] ASCII_HI = 8'h7E;

    function automatic logic len_bytes_legal(input int lb);
        return (lb == 1) || (lb == 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prga_step.sv
`default_nettype none
// ============================================================================
// Module   : prga_step
// Purpose  : RC4 PRGA i/j/si/sj registers and S-box swap datapath, shared by
//            the keystream drop phase and the message phase.
// Revision : 1.0 - initial release
// ============================================================================
module prga_step
    import prga_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [STATE_W-1:0] state,
    input  logic [7:0]         s_rddata,
    output logic [7:0]         s_addr,
    output logic [7:0]         s_wrdata,
    output logic               s_wren
);
    logic [7:0] r_i;
    logic [7:0] r_j;
    logic [7:0] r_si;
    logic [7:0] r_sj;
    logic [7:0] w_j_next;

    // In J_RD the S-box data is S[i]; the new j is needed as an address the same cycle.
    assign w_j_next = r_j + s_rddata;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_i  <= 8'd0;
            r_j  <= 8'd0;
            r_si <= 8'd0;
            r_sj <= 8'd0;
        end else begin
            case (state)
                I_RD:    r_i <= r_i + 8'd1;
                J_RD: begin
                    r_si <= s_rddata;
                    r_j  <= w_j_next;
                end
                SWAP_J:  r_sj <= s_rddata;
                default: ;
            endcase
        end
    end

    always_comb begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
        case (state)
            I_RD:   s_addr = r_i + 8'd1;
            J_RD:   s_addr = w_j_next;
            SWAP_J: begin
                s_addr   = r_j;
                s_wrdata = r_si;
                s_wren   = 1'b1;
            end
            SWAP_I: begin
                s_addr   = r_i;
                s_wrdata = r_sj;
                s_wren   = 1'b1;
            end
            K_RD:   s_addr = r_si + r_sj;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/prga_drop.sv
`default_nettype none
// ============================================================================
// Module   : prga_drop
// Purpose  : RC4-drop[N] decryptor: reads a length-prefixed ciphertext, runs
//            the PRGA over an in-place S-box RAM and writes the plaintext.
//            Define PRGA_ASCII_CHECK_EN to abort on non-printable plaintext.
// Revision : 1.0 - initial release
// ============================================================================
module prga_drop
    import prga_pkg::*;
#(
    parameter int  LEN_BYTES = 1,
    parameter int  DROP_N    = 0,
    localparam int MSG_AW    = 8 * LEN_BYTES + 1,
    localparam int MAX_LEN   = 2 ** (8 * LEN_BYTES) - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic              rdy,
    output logic [7:0]        s_addr,
    input  logic [7:0]        s_rddata,
    output logic [7:0]        s_wrdata,
    output logic              s_wren,
    output logic [MSG_AW-1:0] ct_addr,
    input  logic [7:0]        ct_rddata,
    output logic [MSG_AW-1:0] pt_addr,
    output logic [7:0]        pt_wrdata,
    output logic              pt_wren,
    output logic              pt_ok
);
    localparam int KW = $clog2(MAX_LEN + 1);

    if (!len_bytes_legal(LEN_BYTES)) begin : g_bad_len_bytes
        $error("prga_drop: LEN_BYTES must be 1 or 2");
    end

    logic [STATE_W-1:0] r_state;
    logic [KW-1:0]      r_k;
    logic [KW-1:0]      r_len;
    logic [KW-1:0]      w_len_shift;
    logic [15:0]        r_drop;
    logic               r_dropping;
    logic               w_start;
    logic               w_abort;
    logic [7:0]         w_pt_byte;

    assign w_start   = (r_state == IDLE) && en;
    assign rdy       = (r_state == IDLE);
    assign w_pt_byte = s_rddata ^ ct_rddata;

    // Length bytes arrive LSB first, so shift each new byte in at the top.
    if (LEN_BYTES == 1) begin : g_len_1
        assign w_len_shift = ct_rddata;
    end else begin : g_len_n
        assign w_len_shift = {ct_rddata, r_len[KW-1:8]};
    end

`ifdef PRGA_ASCII_CHECK_EN
    logic r_pt_ok;
    assign w_abort = (r_state == PT_WR) &&
                     ((w_pt_byte < ASCII_LO) || (w_pt_byte > ASCII_HI));
    always_ff @(posedge clk) begin
        if (rst || w_start) begin
            r_pt_ok <= 1'b1;
        end else if (w_abort) begin
            r_pt_ok <= 1'b0;
        end
    end
    assign pt_ok = r_pt_ok;
`else
    assign w_abort = 1'b0;
    assign pt_ok   = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_len      <= '0;
            r_drop     <= 16'd0;
            r_dropping <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (en) begin
                        r_state <= LEN_RD;
                        r_k     <= '0;
                    end
                end
                LEN_RD: begin
                    if (r_k != '0) begin
                        r_len <= w_len_shift;
                    end
                    if (r_k == KW'(LEN_BYTES)) begin
                        r_k    <= '0;
                        r_drop <= 16'd0;
                        if (DROP_N != 0) begin
                            r_dropping <= 1'b1;
                            r_state    <= I_RD;
                        end else if (w_len_shift == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= I_RD;
                        end
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                I_RD:   r_state <= J_RD;
                J_RD:   r_state <= SWAP_J;
                SWAP_J: r_state <= SWAP_I;
                SWAP_I: begin
                    if (!r_dropping) begin
                        r_state <= K_RD;
                    end else if (r_drop == 16'(DROP_N - 1)) begin
                        r_dropping <= 1'b0;
                        r_state    <= (r_len == '0) ? DONE : I_RD;
                    end else begin
                        r_drop  <= r_drop + 16'd1;
                        r_state <= I_RD;
                    end
                end
                K_RD:   r_state <= PT_WR;
                PT_WR: begin
                    if (w_abort || (r_k == r_len - KW'(1))) begin
                        r_state <= DONE;
                    end else begin
                        r_k     <= r_k + KW'(1);
                        r_state <= I_RD;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    prga_step u_step (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_start),
        .state    (r_state),
        .s_rddata (s_rddata),
        .s_addr   (s_addr),
        .s_wrdata (s_wrdata),
        .s_wren   (s_wren)
    );

    // Length field is copied through as it is read; payload sits after it.
    always_comb begin
        ct_addr   = MSG_AW'(r_k) + MSG_AW'(LEN_BYTES);
        pt_addr   = '0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        if (r_state == LEN_RD) begin
            ct_addr = MSG_AW'(r_k);
            if (r_k != '0) begin
                pt_addr   = MSG_AW'(r_k - KW'(1));
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
            end
        end else if (r_state == PT_WR) begin
            pt_addr   = MSG_AW'(r_k) + MSG_AW'(LEN_BYTES);
            pt_wrdata = w_pt_byte;
            pt_wren   = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/prga_drop.md
PRGA_DROP -- requirements
Module: prga_drop

Interface
REQ-001 Parameter LEN_BYTES, default 1; width of the little-endian length prefix at ct[0..LEN_BYTES-1] and pt[0..LEN_BYTES-1]; legal values 1 and 2.
REQ-002 Parameter DROP_N, default 0; number of keystream bytes generated and discarded before the first message byte (RC4-drop[N]); legal range 0..65535.
REQ-003 Localparams: MSG_AW = 8*LEN_BYTES+1 (message address width) and MAX_LEN = 2**(8*LEN_BYTES)-1.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  start request; sampled only while rdy=1.
REQ-007 rdy  out  1  high only in IDLE.
REQ-008 s_addr/s_rddata/s_wrdata/s_wren  out/in/out/out  8/8/8/1  S-box RAM port; 256x8, 1-cycle synchronous read.
REQ-009 ct_addr/ct_rddata  out/in  MSG_AW/8  ciphertext RAM read port; 1-cycle read latency.
REQ-010 pt_addr/pt_wrdata/pt_wren  out/out/out  MSG_AW/8/1  plaintext RAM write port.
REQ-011 pt_ok  out  1  result flag; valid while rdy=1.

Function
REQ-012 All RAM outputs SHALL be driven combinationally from state plus registers; every wren SHALL be 0 in any state that does not perform a write.
REQ-013 When en=1 in IDLE: i, j, and the byte counter SHALL clear to 0, pt_ok SHALL set to 1, and rdy SHALL fall on the next cycle.
REQ-014 en while rdy=0 SHALL be ignored; no request queuing.
REQ-015 LEN phase: read ct[0..LEN_BYTES-1] in LEN_BYTES+1 cycles; assemble L little-endian; write L to pt[0..LEN_BYTES-1] unchanged.
REQ-016 States: IDLE, LEN_RD, I_RD, J_RD, SWAP_J, SWAP_I, K_RD, PT_WR, DONE.
REQ-017 Per keystream byte: I_RD addr S[i+1]; J_RD latch si, j += si, addr S[j]; SWAP_J latch sj, write S[j]=si; SWAP_I write S[i]=sj; K_RD addr S[si+sj] and ct[LEN_BYTES+k]; PT_WR write pt[LEN_BYTES+k] = S[si+sj] ^ ct byte.
REQ-018 Each message byte therefore SHALL take exactly 6 cycles.
REQ-019 i, j, and the S-address sums SHALL be 8-bit and wrap modulo 256; k SHALL be 8*LEN_BYTES bits wide.
REQ-020 Drop phase: DROP_N iterations of I_RD..SWAP_I; no pt/ct access; 4 cycles each; runs before the first message byte.
REQ-021 After byte k=L-1: go to DONE, then IDLE (rdy=1) one cycle later.
REQ-022 L=0: write the length field, perform the drop phase, then go to DONE; no payload writes.
REQ-023 S SHALL be modified in place; the caller reloads the key schedule before every run.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE, rdy=1, pt_ok=1, and i=j=k=0.
REQ-025 All write enables SHALL be 0 from that edge on, including when reset is asserted mid-operation; partially written pt contents are undefined.

Configuration
REQ-026 Macro PRGA_ASCII_CHECK_EN defined: each PT_WR byte outside 0x20..0x7E SHALL clear pt_ok and go to DONE after the write (early abort).
REQ-027 Macro PRGA_ASCII_CHECK_EN undefined: pt_ok SHALL be tied to 1, with no abort path and no extra logic.

Structure
REQ-028 Package prga_pkg SHALL hold the state enum, ASCII_LO=8'h20, ASCII_HI=8'h7E, and the LEN_BYTES legality check.
REQ-029 Sub-module prga_step SHALL hold the i/j/si/sj registers and swap datapath, shared by the drop and message phases.

Verification
REQ-030 Preload S = KSA("Key") (bench model) and ct = {9, BB F3 16 E8 D9 40 AF 0A D3} -> pt = {9, "Plaintext"}, pt_ok=1, rdy returns after exactly 2+1+9*6+1 cycles from en.
REQ-031 L=0 with DROP_N=0 -> only pt[0]=0 is written, S unchanged, rdy back 4 cycles after en.
REQ-032 DROP_N=768, key "Key", L=9 -> pt matches the bench RC4-drop768 model byte for byte.
REQ-033 LEN_BYTES=2, L=300, random S permutation -> i wraps past 255 correctly and all 300 bytes match the model.
REQ-034 With PRGA_ASCII_CHECK_EN, a ct whose 3rd plaintext byte decrypts to 0x07 -> pt_ok=0, exactly 3 payload writes, then rdy.
REQ-035 Assert rst during byte 4 of a 9-byte run -> the next cycle shows rdy=1 and all wren 0; a rerun after reloading S gives correct pt.
